// File: rtl/reg_id_exe_pipe.sv
// reg_id_exe_pipe: ID/EX pipeline register with stall hold, flush and load-use bubble insertion,
// R-type ALU op resolution and a saturating bubble counter.
module reg_id_exe_pipe #(
    parameter int DATA_W     = 32,
    parameter int REG_W      = 5,
    parameter int PC_W       = 8,
    parameter int ALU_OP_W   = 6,
    parameter int EXE_W      = 4,
    parameter int MEM_W      = 3,
    parameter int WB_W       = 2,
    parameter int MEM_RD_BIT = 1,
    parameter int CNT_W      = 16
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                stall_in,
    input  logic                flush_in,
    input  logic                valid_in,
    input  logic [EXE_W-1:0]    control_exe_in,
    input  logic [MEM_W-1:0]    control_mem_in,
    input  logic [WB_W-1:0]     control_wb_in,
    input  logic [ALU_OP_W-1:0] alu_op_in,
    input  logic [PC_W-1:0]     pc_in,
    input  logic [DATA_W-1:0]   read_data_1_in,
    input  logic [DATA_W-1:0]   read_data_2_in,
    input  logic [DATA_W-1:0]   sign_extend_in,
    input  logic [REG_W-1:0]    rs_in,
    input  logic [REG_W-1:0]    rt_in,
    input  logic [REG_W-1:0]    rd_in,
    output logic                valid_out,
    output logic [EXE_W-1:0]    control_exe_out,
    output logic [MEM_W-1:0]    control_mem_out,
    output logic [WB_W-1:0]     control_wb_out,
    output logic [ALU_OP_W-1:0] alu_op_out,
    output logic [PC_W-1:0]     pc_out,
    output logic [DATA_W-1:0]   read_data_1_out,
    output logic [DATA_W-1:0]   read_data_2_out,
    output logic [DATA_W-1:0]   sign_extend_out,
    output logic [REG_W-1:0]    rs_out,
    output logic [REG_W-1:0]    rt_out,
    output logic [REG_W-1:0]    rd_out,
    output logic                hazard_stall,
    output logic [CNT_W-1:0]    bubble_count
);
    logic                bubble;
    logic [ALU_OP_W-1:0] alu_op_res;

    assign hazard_stall = valid_out & control_mem_out[MEM_RD_BIT] & valid_in & (rt_out != '0) &
                          ((rt_out == rs_in) | (rt_out == rt_in));
    assign bubble       = flush_in | hazard_stall;
    assign alu_op_res   = (alu_op_in != '0) ? alu_op_in : sign_extend_in[ALU_OP_W-1:0];

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            valid_out       <= 1'b0;
            control_exe_out <= '0;
            control_mem_out <= '0;
            control_wb_out  <= '0;
            alu_op_out      <= '0;
            pc_out          <= '0;
            read_data_1_out <= '0;
            read_data_2_out <= '0;
            sign_extend_out <= '0;
            rs_out          <= '0;
            rt_out          <= '0;
            rd_out          <= '0;
            bubble_count    <= '0;
        end else if (!stall_in) begin
            valid_out       <= valid_in & ~bubble;
            control_exe_out <= bubble ? '0 : control_exe_in;
            control_mem_out <= bubble ? '0 : control_mem_in;
            control_wb_out  <= bubble ? '0 : control_wb_in;
            alu_op_out      <= bubble ? '0 : alu_op_res;
            // datapath fields load even on a bubble so they stay deterministic
            pc_out          <= pc_in;
            read_data_1_out <= read_data_1_in;
            read_data_2_out <= read_data_2_in;
            sign_extend_out <= sign_extend_in;
            rs_out          <= rs_in;
            rt_out          <= rt_in;
            rd_out          <= rd_in;
            if (bubble && !(&bubble_count))
                bubble_count <= bubble_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_reg_id_exe_pipe.sv
// tb_reg_id_exe_pipe: directed vectors, a slot-level reference model compared every cycle,
// and hand-computed literal checks; a second instance with a 2-bit counter covers saturation.
module tb_reg_id_exe_pipe;
    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        stall_in = 1'b0, flush_in = 1'b0, valid_in = 1'b0;
    logic [3:0]  control_exe_in = '0;
    logic [2:0]  control_mem_in = '0;
    logic [1:0]  control_wb_in = '0;
    logic [5:0]  alu_op_in = '0;
    logic [7:0]  pc_in = '0;
    logic [31:0] read_data_1_in = '0, read_data_2_in = '0, sign_extend_in = '0;
    logic [4:0]  rs_in = '0, rt_in = '0, rd_in = '0;

    logic        valid_out, hazard_stall;
    logic [3:0]  control_exe_out;
    logic [2:0]  control_mem_out;
    logic [1:0]  control_wb_out;
    logic [5:0]  alu_op_out;
    logic [7:0]  pc_out;
    logic [31:0] read_data_1_out, read_data_2_out, sign_extend_out;
    logic [4:0]  rs_out, rt_out, rd_out;
    logic [15:0] bubble_count;

    logic        u_valid, u_haz;
    logic [3:0]  u_ce;
    logic [2:0]  u_cm;
    logic [1:0]  u_cw;
    logic [5:0]  u_alu;
    logic [7:0]  u_pc;
    logic [31:0] u_r1, u_r2, u_se;
    logic [4:0]  u_rs, u_rt, u_rd;
    logic [1:0]  bubble_count2;

    int n_chk = 0, n_fail = 0;

    always #5 CLK = ~CLK;

    reg_id_exe_pipe dut (
        .CLK(CLK), .RST_N(RST_N), .stall_in(stall_in), .flush_in(flush_in), .valid_in(valid_in),
        .control_exe_in(control_exe_in), .control_mem_in(control_mem_in), .control_wb_in(control_wb_in),
        .alu_op_in(alu_op_in), .pc_in(pc_in), .read_data_1_in(read_data_1_in),
        .read_data_2_in(read_data_2_in), .sign_extend_in(sign_extend_in),
        .rs_in(rs_in), .rt_in(rt_in), .rd_in(rd_in), .valid_out(valid_out),
        .control_exe_out(control_exe_out), .control_mem_out(control_mem_out),
        .control_wb_out(control_wb_out), .alu_op_out(alu_op_out), .pc_out(pc_out),
        .read_data_1_out(read_data_1_out), .read_data_2_out(read_data_2_out),
        .sign_extend_out(sign_extend_out), .rs_out(rs_out), .rt_out(rt_out), .rd_out(rd_out),
        .hazard_stall(hazard_stall), .bubble_count(bubble_count)
    );

    reg_id_exe_pipe #(.CNT_W(2)) dut2 (
        .CLK(CLK), .RST_N(RST_N), .stall_in(stall_in), .flush_in(flush_in), .valid_in(valid_in),
        .control_exe_in(control_exe_in), .control_mem_in(control_mem_in), .control_wb_in(control_wb_in),
        .alu_op_in(alu_op_in), .pc_in(pc_in), .read_data_1_in(read_data_1_in),
        .read_data_2_in(read_data_2_in), .sign_extend_in(sign_extend_in),
        .rs_in(rs_in), .rt_in(rt_in), .rd_in(rd_in), .valid_out(u_valid),
        .control_exe_out(u_ce), .control_mem_out(u_cm), .control_wb_out(u_cw),
        .alu_op_out(u_alu), .pc_out(u_pc), .read_data_1_out(u_r1), .read_data_2_out(u_r2),
        .sign_extend_out(u_se), .rs_out(u_rs), .rt_out(u_rt), .rd_out(u_rd),
        .hazard_stall(u_haz), .bubble_count(bubble_count2)
    );

    typedef struct {
        logic        v;
        logic [3:0]  ce;
        logic [2:0]  cm;
        logic [1:0]  cw;
        logic [5:0]  alu;
        logic [7:0]  pc;
        logic [31:0] r1, r2, se;
        logic [4:0]  rs, rt, rd;
    } slot_t;

    slot_t m;
    int    cnt, cnt2;

    // A real load in EX whose destination the decode instruction reads must stall decode.
    function automatic logic exp_haz();
        return m.v && m.cm[1] && valid_in && m.rt != 0 && (m.rt == rs_in || m.rt == rt_in);
    endfunction

    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            m = '{default: '0};
            cnt = 0;
            cnt2 = 0;
        end else if (!stall_in) begin
            automatic logic  bub = flush_in || exp_haz();
            automatic slot_t n;
            n.v   = valid_in;
            n.ce  = control_exe_in;
            n.cm  = control_mem_in;
            n.cw  = control_wb_in;
            n.alu = (alu_op_in != 0) ? alu_op_in : sign_extend_in[5:0];
            n.pc  = pc_in;
            n.r1  = read_data_1_in;
            n.r2  = read_data_2_in;
            n.se  = sign_extend_in;
            n.rs  = rs_in;
            n.rt  = rt_in;
            n.rd  = rd_in;
            if (bub) begin
                n.v = 0; n.ce = 0; n.cm = 0; n.cw = 0; n.alu = 0;
                cnt  = (cnt  < 65535) ? cnt + 1 : cnt;
                cnt2 = (cnt2 < 3)     ? cnt2 + 1 : cnt2;
            end
            m = n;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge CLK) begin
        chk("valid_out", 64'(valid_out), 64'(m.v));
        chk("control_exe_out", 64'(control_exe_out), 64'(m.ce));
        chk("control_mem_out", 64'(control_mem_out), 64'(m.cm));
        chk("control_wb_out", 64'(control_wb_out), 64'(m.cw));
        chk("alu_op_out", 64'(alu_op_out), 64'(m.alu));
        chk("pc_out", 64'(pc_out), 64'(m.pc));
        chk("read_data_1_out", 64'(read_data_1_out), 64'(m.r1));
        chk("read_data_2_out", 64'(read_data_2_out), 64'(m.r2));
        chk("sign_extend_out", 64'(sign_extend_out), 64'(m.se));
        chk("rs_out", 64'(rs_out), 64'(m.rs));
        chk("rt_out", 64'(rt_out), 64'(m.rt));
        chk("rd_out", 64'(rd_out), 64'(m.rd));
        chk("hazard_stall", 64'(hazard_stall), 64'(exp_haz()));
        chk("bubble_count", 64'(bubble_count), 64'(cnt));
        chk("bubble_count2", 64'(bubble_count2), 64'(cnt2));
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic load(input logic v, input logic [3:0] ce, input logic [2:0] cm, input logic [1:0] cw,
                        input logic [5:0] alu, input logic [7:0] pc, input logic [31:0] r1,
                        input logic [31:0] se, input logic [4:0] rs, input logic [4:0] rt);
        valid_in = v; control_exe_in = ce; control_mem_in = cm; control_wb_in = cw;
        alu_op_in = alu; pc_in = pc; read_data_1_in = r1; read_data_2_in = r1 ^ 32'h5A5A_5A5A;
        sign_extend_in = se; rs_in = rs; rt_in = rt; rd_in = rs ^ rt;
    endtask

    initial begin
        tick();
        tick();
        chk("rst valid_out", 64'(valid_out), 64'd0);
        chk("rst pc_out", 64'(pc_out), 64'd0);
        chk("rst bubble_count", 64'(bubble_count), 64'd0);
        RST_N = 1'b1;

        load(1, 4'h3, 3'b000, 2'b01, 6'h08, 8'h10, 32'hDEAD_BEEF, 32'h0000_0004, 5'd1, 5'd2);
        tick();
        chk("load valid_out", 64'(valid_out), 64'd1);
        chk("load alu_op_out", 64'(alu_op_out), 64'h08);
        chk("load pc_out", 64'(pc_out), 64'h10);
        chk("load read_data_1_out", 64'(read_data_1_out), 64'hDEAD_BEEF);

        load(1, 4'h2, 3'b000, 2'b10, 6'h00, 8'h14, 32'h1234_5678, 32'h0000_0020, 5'd3, 5'd4);
        tick();
        chk("rtype alu_op_out", 64'(alu_op_out), 64'h20);

        load(1, 4'h1, 3'b010, 2'b11, 6'h23, 8'h18, 32'h0000_0100, 32'h0000_0008, 5'd9, 5'd8);
        tick();
        load(1, 4'hF, 3'b000, 2'b11, 6'h21, 8'h1C, 32'h0000_0200, 32'h0000_0000, 5'd8, 5'd3);
        #1;
        chk("loaduse hazard_stall", 64'(hazard_stall), 64'd1);
        tick();
        chk("bubble valid_out", 64'(valid_out), 64'd0);
        chk("bubble control_exe_out", 64'(control_exe_out), 64'd0);
        chk("bubble control_mem_out", 64'(control_mem_out), 64'd0);
        chk("bubble alu_op_out", 64'(alu_op_out), 64'd0);
        chk("bubble bubble_count", 64'(bubble_count), 64'd1);

        load(1, 4'h1, 3'b010, 2'b11, 6'h23, 8'h20, 32'h0000_0300, 32'h0000_0000, 5'd9, 5'd0);
        tick();
        load(1, 4'h4, 3'b000, 2'b01, 6'h02, 8'h24, 32'h0000_0400, 32'h0000_0000, 5'd0, 5'd0);
        #1;
        chk("rt0 hazard_stall", 64'(hazard_stall), 64'd0);
        tick();

        load(0, 4'h7, 3'b101, 2'b10, 6'h05, 8'h28, 32'h0000_0500, 32'h0000_0000, 5'd6, 5'd7);
        tick();
        chk("invalid load valid_out", 64'(valid_out), 64'd0);
        chk("invalid load control_exe_out", 64'(control_exe_out), 64'h7);
        chk("invalid load bubble_count", 64'(bubble_count), 64'd1);

        load(1, 4'h5, 3'b000, 2'b11, 6'h11, 8'h40, 32'hCAFE_F00D, 32'h0000_0000, 5'd10, 5'd11);
        tick();
        load(1, 4'h9, 3'b001, 2'b01, 6'h12, 8'h44, 32'h0BAD_0BAD, 32'h0000_0000, 5'd12, 5'd13);
        stall_in = 1'b1;
        flush_in = 1'b1;
        repeat (3) tick();
        chk("stall valid_out", 64'(valid_out), 64'd1);
        chk("stall control_exe_out", 64'(control_exe_out), 64'h5);
        chk("stall pc_out", 64'(pc_out), 64'h40);
        chk("stall bubble_count", 64'(bubble_count), 64'd1);
        stall_in = 1'b0;
        tick();
        flush_in = 1'b0;
        chk("flush valid_out", 64'(valid_out), 64'd0);
        chk("flush bubble_count", 64'(bubble_count), 64'd2);

        load(1, 4'h6, 3'b010, 2'b11, 6'h2A, 8'h50, 32'h7777_0000, 32'h0000_0000, 5'd14, 5'd15);
        tick();
        #2;
        RST_N = 1'b0;
        #1;
        chk("async valid_out", 64'(valid_out), 64'd0);
        chk("async control_exe_out", 64'(control_exe_out), 64'd0);
        chk("async pc_out", 64'(pc_out), 64'd0);
        chk("async read_data_1_out", 64'(read_data_1_out), 64'd0);
        chk("async bubble_count", 64'(bubble_count), 64'd0);
        chk("async bubble_count2", 64'(bubble_count2), 64'd0);
        tick();
        RST_N = 1'b1;

        flush_in = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("sat bubble_count2", 64'(bubble_count2), 64'((i < 3) ? i + 1 : 3));
            chk("sat bubble_count", 64'(bubble_count), 64'(i + 1));
        end
        flush_in = 1'b0;
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
